// File: rtl/adc_spi_interface.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_interface
// Description : SPI master front end for a serial ADC. It sends a configuration
//               stream once, then runs continuous 128-bit read frames.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_interface #(
  parameter logic [79:0] CFG_BITS = 80'hA5A5_0000_0000_0000_5A5A
) (
  input  logic         SCLK,
  input  logic         RESET_N,
  input  logic         SDO1,
  output logic         SDI1,
  output logic         SYNC1,
  output logic [127:0] serial_read
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONFIG = 2'd1,
    S_GAP    = 2'd2,
    S_READ   = 2'd3
  } state_t;

  localparam logic [6:0] C_CFG_LAST  = 7'd80;
  localparam logic [6:0] C_READ_LAST = 7'd127;
  localparam logic [6:0] C_CFG_MSB   = 7'd79;

  state_t       r_state;
  logic [6:0]   r_cnt;
  logic [127:0] r_shift;
  logic [127:0] r_serial_read;
  logic         r_sdi;
  logic         r_sync;

  logic [6:0]   w_cfg_idx;
  logic [127:0] w_next_shift;
  logic         w_unused_shift_msb;

  // In CONFIG the counter equals the edge number, so it selects bit 79-e.
  assign w_cfg_idx          = C_CFG_MSB - r_cnt;
  assign w_next_shift       = {r_shift[126:0], SDO1};
  assign w_unused_shift_msb = r_shift[127];

  assign SDI1        = r_sdi;
  assign SYNC1       = r_sync;
  assign serial_read = r_serial_read;

  always_ff @(posedge SCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_cnt         <= 7'd0;
      r_shift       <= 128'd0;
      r_serial_read <= 128'd0;
      r_sdi         <= 1'b0;
      r_sync        <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_CONFIG;
          r_sync  <= 1'b0;
          r_sdi   <= CFG_BITS[79];
          r_cnt   <= 7'd1;
        end
        S_CONFIG: begin
          if (r_cnt == C_CFG_LAST) begin
            r_state <= S_GAP;
            r_sync  <= 1'b1;
            r_sdi   <= 1'b0;
            r_cnt   <= 7'd0;
          end else begin
            r_sdi <= CFG_BITS[w_cfg_idx];
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_GAP: begin
          r_state <= S_READ;
          r_sync  <= 1'b0;
          r_sdi   <= 1'b0;
          r_cnt   <= 7'd0;
        end
        S_READ: begin
          r_shift <= w_next_shift;
          r_sdi   <= 1'b0;
          // Publish only on the final sample so no partial frame is visible.
          if (r_cnt == C_READ_LAST) begin
            r_serial_read <= w_next_shift;
            r_sync        <= 1'b1;
            r_state       <= S_GAP;
            r_cnt         <= 7'd0;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sync  <= 1'b1;
          r_sdi   <= 1'b0;
          r_cnt   <= 7'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_spi_interface
// Description : Self-checking bench for adc_spi_interface with a frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_interface;

  localparam logic [79:0] C_CFG = 80'hA5A5_0000_0000_0000_5A5A;

  logic         SCLK;
  logic         RESET_N;
  logic         SDO1;
  logic         SDI1;
  logic         SYNC1;
  logic [127:0] serial_read;

  int           n_checks;
  int           n_fail;
  logic [127:0] sb_q[$];
  logic [127:0] exp_sr;

  adc_spi_interface #(.CFG_BITS(C_CFG)) dut (
    .SCLK        (SCLK),
    .RESET_N     (RESET_N),
    .SDO1        (SDO1),
    .SDI1        (SDI1),
    .SYNC1       (SYNC1),
    .serial_read (serial_read)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic release_reset();
    @(negedge SCLK);
    RESET_N = 1'b1;
  endtask

  // Edges 0..80: capture the configuration stream and the first gap.
  task automatic run_config(input string tag);
    logic [79:0] cap;
    bit          sync_ok;
    cap     = '0;
    sync_ok = 1'b1;
    for (int e = 0; e < 80; e++) begin
      tick();
      if (SYNC1 !== 1'b0) sync_ok = 1'b0;
      cap = {cap[78:0], SDI1};
    end
    check({tag, "_cfg_stream"}, {48'd0, cap}, {48'd0, C_CFG});
    check({tag, "_cfg_sync_low"}, {127'd0, sync_ok}, 128'd1);
    tick();
    check({tag, "_gap_sync"}, {127'd0, SYNC1}, 128'd1);
    check({tag, "_gap_sdi"}, {127'd0, SDI1}, 128'd0);
    check({tag, "_gap_sr"}, serial_read, exp_sr);
  endtask

  // GAP->READ edge plus 128 samples; n_samples < 128 stops early for abort tests.
  task automatic run_frame(input string tag, input logic [127:0] d, input int n_samples);
    bit hold_ok;
    bit sdi_ok;
    bit sync_ok;
    hold_ok = 1'b1;
    sdi_ok  = 1'b1;
    sync_ok = 1'b1;
    @(negedge SCLK);
    SDO1 = ~d[127];
    tick();
    check({tag, "_read_sync"}, {127'd0, SYNC1}, 128'd0);
    if (n_samples == 128) sb_q.push_back(d);
    for (int i = 0; i < n_samples; i++) begin
      @(negedge SCLK);
      SDO1 = d[127-i];
      tick();
      if (SDI1 !== 1'b0) sdi_ok = 1'b0;
      if (i < 127) begin
        if (serial_read !== exp_sr) hold_ok = 1'b0;
        if (SYNC1 !== 1'b0) sync_ok = 1'b0;
      end
    end
    check({tag, "_sr_hold"}, {127'd0, hold_ok}, 128'd1);
    check({tag, "_sdi_zero"}, {127'd0, sdi_ok}, 128'd1);
    check({tag, "_sync_low"}, {127'd0, sync_ok}, 128'd1);
    if (n_samples == 128) begin
      check({tag, "_end_sync"}, {127'd0, SYNC1}, 128'd1);
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 128'd0, 128'd1);
      end else begin
        exp_sr = sb_q.pop_front();
        check({tag, "_data"}, serial_read, exp_sr);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_sr   = '0;
    RESET_N  = 1'b0;
    SDO1     = 1'b0;

    repeat (3) tick();
    check("rst_sync", {127'd0, SYNC1}, 128'd1);
    check("rst_sdi", {127'd0, SDI1}, 128'd0);
    check("rst_sr", serial_read, 128'd0);

    release_reset();
    run_config("p1");
    run_frame("f_pat", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128);
    run_frame("f_ones", {128{1'b1}}, 128);
    run_frame("f_alt", {64{2'b10}}, 128);
    run_frame("f_rnd", {$urandom, $urandom, $urandom, $urandom}, 128);

    // Asynchronous reset between edges, mid-READ.
    run_frame("f_abort1", {$urandom, $urandom, $urandom, $urandom}, 40);
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst_sync", {127'd0, SYNC1}, 128'd1);
    check("arst_sdi", {127'd0, SDI1}, 128'd0);
    check("arst_sr", serial_read, 128'd0);
    exp_sr = '0;
    sb_q.delete();

    // Restart: config re-sent, then abort first frame at edge 150.
    release_reset();
    run_config("p2");
    run_frame("f_abort2", {128{1'b1}}, 68);
    @(negedge SCLK);
    RESET_N = 1'b0;
    #1;
    check("abort_sr", serial_read, 128'd0);
    release_reset();
    run_config("p3");
    check("p3_sr_zero", serial_read, 128'd0);
    run_frame("f_rnd2", {$urandom, $urandom, $urandom, $urandom}, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
